dct_da_sequencer: RTL
=====================

// Module: dct_da_sequencer
// PURPOSE
// Sequencer for the 8-point bit-serial distributed-arithmetic DCT coefficient units (Z0..Z7).
// - Gathers 8 EEG samples from a valid/ready stream into ping-pong banks.
// - Drives load/shift/clear/sign-cycle controls for one 8-bit serial pass.
// - Captures the 8 coefficients and serialises them, index order 0..7, to the RLE stage.
// - Replaces the divided clk8 capture clock with single-clock enables.
// PARAMETERS
// SAMPLE_W  8   sample width; also the number of bit-serial SHIFT cycles per block
// N_PTS     8   samples per block = coefficient units driven (fixed 8; other values unsupported)
// COEF_W    18  coefficient width returned by each DA unit
// PORTS
// clk        in   1               single system clock, rising edge
// reset      in   1               synchronous, active-high
// in_data    in   SAMPLE_W        signed EEG sample
// in_valid   in   1               sample offered
// in_ready   out  1               sample accepted when in_valid&in_ready
// x_par      out  N_PTS*SAMPLE_W  compute-bank block to DA shifters; x0 in bits [7:0]
// dp_load    out  1               1-cycle pulse: shifters parallel-load x_par
// dp_acc_clr out  1               1-cycle pulse with dp_load: accumulators clear
// dp_shift   out  1               shifter/accumulator enable, 8 consecutive cycles
// dp_sign    out  1               high on the last (MSB) shift cycle -> units subtract
// dp_cs      out  1               ROM chip select, high during LOAD and SHIFT
// coef_in    in   N_PTS*COEF_W    DA unit outputs; Z0 in bits [17:0]
// out_coef   out  COEF_W          serialised coefficient
// out_idx    out  3               coefficient index 0..7
// out_last   out  1               high with index 7
// out_valid  out  1               coefficient offered
// out_ready  in   1               RLE accepts when out_valid&out_ready
// busy       out  1               FSM not IDLE, or output bank non-empty
// stall_cnt  out  16              cycles spent in WAIT_OUT (see CONFIGURATION)
// BEHAVIOUR
// - Reset values: in_ready=0 while reset=1, =1 from the first cycle after.
//   All other outputs 0; both banks empty; FSM=IDLE.
// - Reset mid-operation: aborts any pass and any drain; partial blocks are discarded.
// Input banks
// - fill_ptr 0..7 writes the fill bank; on the 8th accept the bank is marked full and the pointer swaps banks.
// - in_ready = fill bank not full.
// - A compute bank is released in the LOAD cycle, because the shifters hold the data from then on.
// - Fill-complete and release in the same cycle are both honoured: no lost sample, no bubble.
// FSM
// - IDLE -> LOAD when a full bank exists.
// - LOAD (1 cycle): dp_load=dp_acc_clr=dp_cs=1, bit_cnt<=0.
// - SHIFT (8 cycles): dp_shift=dp_cs=1, dp_sign=(bit_cnt==7), bit_cnt++.
//   After bit_cnt==7 -> WAIT_OUT if the output bank is busy, else CAPTURE.
// - WAIT_OUT: all dp_* controls 0, so datapath state is frozen. Leave when the output bank is empty.
// - CAPTURE (1 cycle): output bank <= coef_in, out_cnt<=0.
//   Next state is LOAD if a full bank exists, else IDLE.
// Output serialiser
// - out_valid=1 while the bank is loaded.
// - out_coef/out_idx are held stable until the handshake completes.
// - Index advances on each handshake; the bank is empty after the index-7 handshake.
// - The empty flag is visible to the FSM in the same cycle (combinational), so CAPTURE may follow immediately.
// Latency and throughput
// - Latency: 8th sample accepted at cycle T -> LOAD at T+1 -> SHIFT T+2..T+9 -> CAPTURE T+10 -> out_valid at T+11.
// - Sustained throughput: one block per 10 cycles, provided the input and output rates keep up.
// - No arithmetic here; coefficients pass through unmodified, width COEF_W.
// CONFIGURATION
// DCT_SEQ_STALL_CNT_EN
// - Defined: stall_cnt increments every cycle the FSM is in WAIT_OUT.
//   Saturates at 16'hFFFF; cleared only by reset.
// - Undefined: stall_cnt is tied to 16'h0 and no counter logic is built.
// TESTING
// - Reset, then samples 1..8 back-to-back; coef_in stub Zk=k+100, out_ready=1
//   -> dp_load 1 cycle after the 8th accept; dp_shift 8 cycles, dp_sign on the 8th only.
//   -> out_coef 100..107 with out_idx 0..7, out_last at idx 7; first out_valid 11 cycles after the 8th accept.
// - 16 samples continuous, out_ready=1 -> in_ready never drops.
//   -> Second LOAD directly after the first CAPTURE; outputs 100..107 appear twice.
// - out_ready=0 for 20 cycles while 16 samples are streamed -> FSM holds WAIT_OUT with dp_* all 0.
//   -> in_ready=0 once both banks are full; no sample lost once out_ready returns.
//   -> stall_cnt>0 with DCT_SEQ_STALL_CNT_EN defined, 0 without.
// - reset=1 asserted during the 4th SHIFT cycle for 1 cycle -> all outputs 0 next cycle, in_ready=1 after.
//   -> The next 8 samples produce a clean block with no residue of the aborted one.
// - in_valid toggling 1/0 every cycle -> exactly 8 accepts fill a bank.
//   -> Words are placed as x_par[7:0]=1st sample ... x_par[63:56]=8th sample.

Source files
------------

// File: rtl/dct_da_sequencer.sv
// Sequencer for the 8-point bit-serial distributed-arithmetic DCT units.
// Optional stall counter: define DCT_SEQ_STALL_CNT_EN to build it.
module dct_da_sequencer #(
    parameter int SAMPLE_W = 8,
    parameter int N_PTS    = 8,
    parameter int COEF_W   = 18
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SAMPLE_W-1:0]         in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [N_PTS*SAMPLE_W-1:0]   x_par,
    output logic                        dp_load,
    output logic                        dp_acc_clr,
    output logic                        dp_shift,
    output logic                        dp_sign,
    output logic                        dp_cs,
    input  logic [N_PTS*COEF_W-1:0]     coef_in,
    output logic [COEF_W-1:0]           out_coef,
    output logic [2:0]                  out_idx,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic [15:0]                 stall_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_WAIT,
        S_CAPT
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(SAMPLE_W - 1);

    state_t state;
    state_t state_nx;

    logic [N_PTS*SAMPLE_W-1:0] bank [2];
    logic [1:0]                bank_full;
    logic                      fill_sel;
    logic                      comp_sel;
    logic [2:0]                fill_ptr;
    logic [2:0]                bit_cnt;

    logic [N_PTS*COEF_W-1:0]   ob_data;
    logic                      ob_full;
    logic [2:0]                out_cnt;

    logic accept;
    logic fill_done;
    logic have_block;
    logic out_fire;
    logic ob_free;

    assign in_ready   = ~reset & ~bank_full[fill_sel];
    assign accept     = in_valid & in_ready;
    assign fill_done  = accept & (fill_ptr == 3'd7);
    // A bank completing this cycle counts, so LOAD follows the 8th accept directly
    assign have_block = bank_full[comp_sel]
                      | (fill_done & (fill_sel == comp_sel));
    assign out_fire   = ob_full & out_ready;
    // Output bank becomes free in the same cycle as its last handshake
    assign ob_free    = ~ob_full | (out_fire & (out_cnt == 3'd7));

    assign x_par     = bank[comp_sel];
    assign out_valid = ob_full;
    assign out_idx   = out_cnt;
    assign out_last  = ob_full & (out_cnt == 3'd7);
    assign out_coef  = ob_full ? ob_data[out_cnt*COEF_W +: COEF_W] : '0;
    assign busy      = (state != S_IDLE) | ob_full;

    // Ping-pong input banks: fill one while the other feeds the shifters
    always_ff @(posedge clk) begin
        if (reset) begin
            bank[0]   <= '0;
            bank[1]   <= '0;
            bank_full <= 2'b00;
            fill_sel  <= 1'b0;
            comp_sel  <= 1'b0;
            fill_ptr  <= 3'd0;
        end else begin
            if (accept) begin
                bank[fill_sel][fill_ptr*SAMPLE_W +: SAMPLE_W] <= in_data;
                fill_ptr <= fill_ptr + 3'd1;
                if (fill_done) begin
                    bank_full[fill_sel] <= 1'b1;
                    fill_sel            <= ~fill_sel;
                end
            end
            if (state == S_LOAD) begin
                bank_full[comp_sel] <= 1'b0;
                comp_sel            <= ~comp_sel;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_nx   = state;
        dp_load    = 1'b0;
        dp_acc_clr = 1'b0;
        dp_shift   = 1'b0;
        dp_sign    = 1'b0;
        dp_cs      = 1'b0;
        case (state)
            S_IDLE: begin
                if (have_block) state_nx = S_LOAD;
            end
            S_LOAD: begin
                dp_load    = 1'b1;
                dp_acc_clr = 1'b1;
                dp_cs      = 1'b1;
                state_nx   = S_SHIFT;
            end
            S_SHIFT: begin
                dp_shift = 1'b1;
                dp_cs    = 1'b1;
                dp_sign  = (bit_cnt == LAST_BIT);
                if (bit_cnt == LAST_BIT) begin
                    state_nx = ob_free ? S_CAPT : S_WAIT;
                end
            end
            S_WAIT: begin
                if (ob_free) state_nx = S_CAPT;
            end
            S_CAPT: begin
                state_nx = have_block ? S_LOAD : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Serial bit counter for the shift pass
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= 3'd0;
        end else if (state == S_LOAD) begin
            bit_cnt <= 3'd0;
        end else if (state == S_SHIFT) begin
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Output bank: capture all coefficients, then hand them out one per handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            ob_data <= '0;
            ob_full <= 1'b0;
            out_cnt <= 3'd0;
        end else if (state == S_CAPT) begin
            ob_data <= coef_in;
            ob_full <= 1'b1;
            out_cnt <= 3'd0;
        end else if (out_fire) begin
            out_cnt <= out_cnt + 3'd1;
            if (out_cnt == 3'd7) ob_full <= 1'b0;
        end
    end

`ifdef DCT_SEQ_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of cycles held back by a busy output bank
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 16'h0;
        end else if (state == S_WAIT && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'h1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0;
`endif

endmodule
